tm1638_responder: RTL and testbench

Behavioural responder for the TM1638 3-wire serial interface (STB/CLK/DIO) in synthesizable RTL. It sits on the far side of the LED/KEY driver, either looped back inside the FPGA or driven from header pins, so the driver can be exercised without the physical board. It decodes data, address and display-control commands, holds the 16-byte display RAM and brightness state, and returns a 4-byte key-scan frame on read commands.

---
 rtl/tm1638_responder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_tm1638_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder.sv
// tm1638_responder: behavioural far-end model of a TM1638 LED/key driver.
// Decodes data/address/display-control commands arriving on STB/CLK/DIO,
// holds the 16-byte display RAM and brightness state, and returns a
// 4-byte key-scan frame on read commands. Everything runs on CK_i; the
// serial pins are treated as asynchronous and synchronized first.

module tm1638_responder #(
    parameter int C_KEY_W = 8
) (
    input  logic                 CK_i,
    input  logic                 XARST_i,
    input  logic                 SS_i,
    input  logic                 SCLK_i,
    input  logic                 MOSI_i,
    output logic                 MISO_o,
    output logic                 MISO_OE_o,
    input  logic [C_KEY_W-1:0]   KEYS_i,
    output logic [127:0]         DISP_RAM_o,
    output logic                 DISP_ON_o,
    output logic [2:0]           BRIGHT_o,
    output logic [3:0]           ADDR_o,
    output logic                 FRAME_o,
    output logic                 ERR_o
);

    // Transfer states
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;

    // Scan frame: byte n carries key n in bit0 and key n+4 in bit4.
    function automatic logic [31:0] build_frame(input logic [7:0] keys);
        logic [31:0] f;
        f = 32'h0000_0000;
        for (int n = 0; n < 4; n++) begin
            f[8*n]     = keys[n];
            f[8*n + 4] = keys[n + 4];
        end
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Key inputs padded/trimmed to the 8 keys the frame can carry
    // ------------------------------------------------------------------
    logic [7:0]  w_keys_pad;
    logic [31:0] w_frame;

    generate
        if (C_KEY_W >= 8) begin : g_keys_full
            assign w_keys_pad = KEYS_i[7:0];
        end else begin : g_keys_pad
            assign w_keys_pad = {{(8 - C_KEY_W){1'b0}}, KEYS_i};
        end
    endgenerate

    assign w_frame = build_frame(w_keys_pad);

    // ------------------------------------------------------------------
    // Synchronizers and registered edge pulses
    // ------------------------------------------------------------------
    logic r_ss_s1, r_ss_s2, r_ss_d;
    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_mosi_s1, r_mosi_s2;
    logic r_ss_rise, r_ss_fall, r_sclk_rise, r_sclk_fall, r_mosi_bit;

    // Two-stage synchronizers, edge register, and one-CK edge pulses.
    // SS sync resets low so a transfer already in flight at reset release
    // is not mistaken for a new falling edge.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_ss_s1     <= 1'b0;
            r_ss_s2     <= 1'b0;
            r_ss_d      <= 1'b0;
            r_sclk_s1   <= 1'b1;
            r_sclk_s2   <= 1'b1;
            r_sclk_d    <= 1'b1;
            r_mosi_s1   <= 1'b0;
            r_mosi_s2   <= 1'b0;
            r_ss_rise   <= 1'b0;
            r_ss_fall   <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_mosi_bit  <= 1'b0;
        end else begin
            r_ss_s1     <= SS_i;
            r_ss_s2     <= r_ss_s1;
            r_ss_d      <= r_ss_s2;
            r_sclk_s1   <= SCLK_i;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_d    <= r_sclk_s2;
            r_mosi_s1   <= MOSI_i;
            r_mosi_s2   <= r_mosi_s1;
            r_ss_rise   <= r_ss_s2 & ~r_ss_d;
            r_ss_fall   <= ~r_ss_s2 & r_ss_d;
            r_sclk_rise <= r_sclk_s2 & ~r_sclk_d;
            r_sclk_fall <= ~r_sclk_s2 & r_sclk_d;
            r_mosi_bit  <= r_mosi_s2;
        end
    end

    // ------------------------------------------------------------------
    // Transfer engine
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [2:0]  r_bitcnt;
    logic [6:0]  r_shift;
    logic [30:0] r_rd_shift;
    logic        r_rise_seen;
    logic        r_fixed;
    logic        r_wrote;
    logic [3:0]  r_addr;
    logic        r_disp_on;
    logic [2:0]  r_bright;
    logic        r_miso;
    logic        r_miso_oe;
    logic        r_frame_pulse;
    logic        r_err;
    logic [7:0]  r_ram [0:15];

    logic       w_sclk_rise;
    logic [7:0] w_byte;

    // A simultaneous SS rise suppresses the SCLK rise sample.
    assign w_sclk_rise = r_sclk_rise & ~r_ss_rise;
    // Byte as it will be once the current MOSI bit is shifted in (LSB first).
    assign w_byte      = {r_mosi_bit, r_shift};

    // Command decode, RAM writes, read-frame shifting and status flags.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            r_state       <= S_IDLE;
            r_bitcnt      <= 3'd0;
            r_shift       <= 7'd0;
            r_rd_shift    <= 31'd0;
            r_rise_seen   <= 1'b0;
            r_fixed       <= 1'b0;
            r_wrote       <= 1'b0;
            r_addr        <= 4'd0;
            r_disp_on     <= 1'b0;
            r_bright      <= 3'd0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_frame_pulse <= 1'b0;
            r_err         <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_ram[i] <= 8'h00;
            end
        end else begin
            r_frame_pulse <= 1'b0;
            if (r_ss_rise) begin
                // End of transfer: a partially received byte is an error.
                if ((r_state != S_IDLE) && (r_bitcnt != 3'd0)) begin
                    r_err <= 1'b1;
                end else begin
                    r_err <= r_err;
                end
                r_frame_pulse <= r_wrote;
                r_wrote       <= 1'b0;
                r_state       <= S_IDLE;
                r_bitcnt      <= 3'd0;
                r_miso_oe     <= 1'b0;
                r_rise_seen   <= 1'b0;
            end else if (r_ss_fall) begin
                r_state     <= S_CMD;
                r_bitcnt    <= 3'd0;
                r_wrote     <= 1'b0;
                r_miso_oe   <= 1'b0;
                r_rise_seen <= 1'b0;
            end else begin
                case (r_state)
                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_shift  <= w_byte[7:1];
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                case (w_byte[7:6])
                                    2'b01: begin
                                        if (w_byte[1]) begin
                                            r_state     <= S_RDATA;
                                            r_miso_oe   <= 1'b1;
                                            r_miso      <= w_frame[0];
                                            r_rd_shift  <= w_frame[31:1];
                                            r_rise_seen <= 1'b0;
                                        end else begin
                                            r_fixed <= w_byte[2];
                                            r_state <= S_WAIT;
                                        end
                                    end
                                    2'b11: begin
                                        r_addr  <= w_byte[3:0];
                                        r_state <= S_WDATA;
                                    end
                                    2'b10: begin
                                        r_disp_on <= w_byte[3];
                                        r_bright  <= w_byte[2:0];
                                        r_state   <= S_WAIT;
                                    end
                                    default: begin
                                        r_err   <= 1'b1;
                                        r_state <= S_WAIT;
                                    end
                                endcase
                            end else begin
                                r_state <= r_state;
                            end
                        end else begin
                            r_state <= r_state;
                        end
                    end
                    S_WDATA: begin
                        if (w_sclk_rise) begin
                            r_shift  <= w_byte[7:1];
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_ram[r_addr] <= w_byte;
                                r_wrote       <= 1'b1;
                                if (!r_fixed) begin
                                    r_addr <= r_addr + 4'd1;
                                end else begin
                                    r_addr <= r_addr;
                                end
                            end else begin
                                r_wrote <= r_wrote;
                            end
                        end else begin
                            r_state <= r_state;
                        end
                    end
                    S_RDATA: begin
                        // Advance only on a falling edge that follows a rise,
                        // so the fall right after command decode keeps bit0.
                        if (w_sclk_rise) begin
                            r_bitcnt    <= r_bitcnt + 3'd1;
                            r_rise_seen <= 1'b1;
                        end else if (r_sclk_fall && r_rise_seen) begin
                            r_miso      <= r_rd_shift[0];
                            r_rd_shift  <= {1'b0, r_rd_shift[30:1]};
                            r_rise_seen <= 1'b0;
                        end else begin
                            r_rise_seen <= r_rise_seen;
                        end
                    end
                    S_WAIT: begin
                        r_state <= S_WAIT;
                    end
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < 16; g++) begin : g_ram_out
            assign DISP_RAM_o[8*g +: 8] = r_ram[g];
        end
    endgenerate

    assign MISO_o    = r_miso;
    assign MISO_OE_o = r_miso_oe;
    assign DISP_ON_o = r_disp_on;
    assign BRIGHT_o  = r_bright;
    assign ADDR_o    = r_addr;
    assign FRAME_o   = r_frame_pulse;
    assign ERR_o     = r_err;

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: drives STB/CLK/DIO with slow serial
// timing (6 CK per SCLK phase) and checks state against hand-computed values.
`timescale 1ns/1ps

module tb_tm1638_responder;

    logic         clk;
    logic         rst_n;
    logic         ss;
    logic         sclk;
    logic         mosi;
    logic         miso;
    logic         miso_oe;
    logic [7:0]   keys;
    logic [127:0] disp_ram;
    logic         disp_on;
    logic [2:0]   bright;
    logic [3:0]   addr;
    logic         frame;
    logic         err;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;
    logic [7:0] rd_byte;

    tm1638_responder #(.C_KEY_W(8)) dut (
        .CK_i       (clk),
        .XARST_i    (rst_n),
        .SS_i       (ss),
        .SCLK_i     (sclk),
        .MOSI_i     (mosi),
        .MISO_o     (miso),
        .MISO_OE_o  (miso_oe),
        .KEYS_i     (keys),
        .DISP_RAM_o (disp_ram),
        .DISP_ON_o  (disp_on),
        .BRIGHT_o   (bright),
        .ADDR_o     (addr),
        .FRAME_o    (frame),
        .ERR_o      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count FRAME_o pulses
    always @(posedge clk) begin
        if (frame === 1'b1) frame_cnt++;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b0;
            mosi = b[i];
            tick(6);
            sclk = 1'b1;
            tick(6);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b0;
            tick(6);
            b[i] = miso;
            sclk = 1'b1;
            tick(6);
        end
    endtask

    task automatic ss_start;
        ss = 1'b0;
        tick(6);
    endtask

    task automatic ss_end;
        ss = 1'b1;
        tick(8);
    endtask

    initial begin
        rst_n = 1'b0;
        ss    = 1'b1;
        sclk  = 1'b1;
        mosi  = 1'b0;
        keys  = 8'h00;
        tick(3);
        check("rst_ram",     disp_ram, 128'h0);
        check("rst_addr",    {124'h0, addr}, 128'h0);
        check("rst_disp_on", {127'h0, disp_on}, 128'h0);
        check("rst_bright",  {125'h0, bright}, 128'h0);
        check("rst_miso",    {127'h0, miso}, 128'h0);
        check("rst_oe",      {127'h0, miso_oe}, 128'h0);
        check("rst_frame",   {127'h0, frame}, 128'h0);
        check("rst_err",     {127'h0, err}, 128'h0);
        rst_n = 1'b1;
        tick(5);

        // Write path, auto-increment
        ss_start; send_byte(8'h40); ss_end;
        check("data_cmd_no_frame", 128'(frame_cnt), 128'd0);
        ss_start; send_byte(8'hC0); send_byte(8'h3F); send_byte(8'h06); send_byte(8'h5B); ss_end;
        check("auto_ram0", {120'h0, disp_ram[7:0]},   128'h3F);
        check("auto_ram1", {120'h0, disp_ram[15:8]},  128'h06);
        check("auto_ram2", {120'h0, disp_ram[23:16]}, 128'h5B);
        check("auto_addr", {124'h0, addr}, 128'h3);
        check("auto_frame", 128'(frame_cnt), 128'd1);

        // Address wrap
        ss_start; send_byte(8'hCF); send_byte(8'hAA); send_byte(8'h55); ss_end;
        check("wrap_ram15", {120'h0, disp_ram[127:120]}, 128'hAA);
        check("wrap_ram0",  {120'h0, disp_ram[7:0]},     128'h55);
        check("wrap_ram1",  {120'h0, disp_ram[15:8]},    128'h06);
        check("wrap_addr",  {124'h0, addr}, 128'h1);
        check("wrap_frame", 128'(frame_cnt), 128'd2);

        // Fixed-address mode
        ss_start; send_byte(8'h44); ss_end;
        ss_start; send_byte(8'hC5); send_byte(8'h11); send_byte(8'h22); ss_end;
        check("fixed_ram5", {120'h0, disp_ram[47:40]}, 128'h22);
        check("fixed_ram6", {120'h0, disp_ram[55:48]}, 128'h00);
        check("fixed_addr", {124'h0, addr}, 128'h5);
        check("fixed_frame", 128'(frame_cnt), 128'd3);

        // Read path
        keys = 8'h21;
        ss_start;
        check("rd_oe_before", {127'h0, miso_oe}, 128'h0);
        send_byte(8'h42);
        check("rd_oe_decode", {127'h0, miso_oe}, 128'h1);
        check("rd_first_bit", {127'h0, miso}, 128'h1);
        read_byte(rd_byte); check("rd_byte0", {120'h0, rd_byte}, 128'h01);
        read_byte(rd_byte); check("rd_byte1", {120'h0, rd_byte}, 128'h10);
        read_byte(rd_byte); check("rd_byte2", {120'h0, rd_byte}, 128'h00);
        read_byte(rd_byte); check("rd_byte3", {120'h0, rd_byte}, 128'h00);
        check("rd_oe_held", {127'h0, miso_oe}, 128'h1);
        ss_end;
        check("rd_oe_after", {127'h0, miso_oe}, 128'h0);
        check("rd_no_frame", 128'(frame_cnt), 128'd3);
        check("rd_err", {127'h0, err}, 128'h0);

        // Display control and error flag
        ss_start; send_byte(8'h8D); ss_end;
        check("dc_on",     {127'h0, disp_on}, 128'h1);
        check("dc_bright", {125'h0, bright}, 128'h5);
        check("dc_err",    {127'h0, err}, 128'h0);
        ss_start; send_byte(8'h00); ss_end;
        check("bad_cmd_err", {127'h0, err}, 128'h1);

        // Reset, then a partial byte
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(4);
        check("rst2_err", {127'h0, err}, 128'h0);
        check("rst2_on",  {127'h0, disp_on}, 128'h0);
        ss_start; send_bits(8'hC0, 3); ss_end;
        check("partial_err", {127'h0, err}, 128'h1);
        check("partial_ram", disp_ram, 128'h0);

        // Reset mid-transfer
        ss_start; send_byte(8'hC0); send_byte(8'hAB); send_bits(8'hCD, 3);
        rst_n = 1'b0; tick(2);
        check("mid_rst_ram",  disp_ram, 128'h0);
        check("mid_rst_addr", {124'h0, addr}, 128'h0);
        check("mid_rst_err",  {127'h0, err}, 128'h0);
        check("mid_rst_oe",   {127'h0, miso_oe}, 128'h0);
        check("mid_rst_miso", {127'h0, miso}, 128'h0);
        rst_n = 1'b1; tick(2);
        send_bits(8'hFF, 5); ss_end;
        check("mid_rest_ram", disp_ram, 128'h0);
        check("mid_rest_err", {127'h0, err}, 128'h0);
        ss_start; send_byte(8'hC0); send_byte(8'h77); ss_end;
        check("fresh_ram",  disp_ram, 128'h77);
        check("fresh_addr", {124'h0, addr}, 128'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
